// File: rtl/capture_ram_sequencer.sv
// capture_ram_sequencer: 4-channel post-trigger capture into a single-port RAM,
// then drain over valid/ready. Option macro CAPTURE_TAG_EN tags the channel.
module capture_ram_sequencer #(
    parameter int TURN_MAX   = 50000,
    parameter int SAMP_START = 49820,
    parameter int POINTS     = 180,
    parameter int RD_LAT     = 2
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Samp_en,
    input  logic        one_turn,
    input  logic [13:0] data_in0,
    input  logic [13:0] data_in1,
    input  logic [13:0] data_in2,
    input  logic [13:0] data_in3,
    output logic [9:0]  ram_addr,
    output logic [15:0] ram_wdata,
    output logic        ram_wren,
    input  logic [15:0] ram_q,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
);
    localparam logic [9:0]  LAST_ADDR = 10'(POINTS * 4 - 1);
    localparam logic [7:0]  LAST_PT   = 8'(POINTS - 1);
    localparam logic [15:0] TURN_LAST = 16'(TURN_MAX - 1);
    localparam logic [15:0] START_CNT = 16'(SAMP_START);
    localparam logic [3:0]  WAIT_LAST = 4'(RD_LAT - 2);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_CAPTURE, S_DRAIN_RD, S_DRAIN_WAIT, S_DRAIN_TX
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_s0, r_s1, r_s2;
    logic [15:0] r_turn_cnt;
    logic [13:0] r_data [4];
    logic        r_burst;
    logic [1:0]  r_ch;
    logic [7:0]  r_pt;
    logic [9:0]  r_rd_addr;
    logic [3:0]  r_wait;
    logic        w_edge, w_start_hit, w_accept, w_last_word;
    logic        w_burst_end, w_draining, w_latch;
    logic [13:0] w_wsel;

    assign w_edge      = r_s1 & ~r_s2;
    assign w_start_hit = w_edge && (r_turn_cnt == START_CNT);
    assign w_accept    = tx_valid & tx_ready;
    assign w_last_word = (r_rd_addr == LAST_ADDR);
    assign w_burst_end = r_burst && (r_ch == 2'd3);
    assign w_draining  = (r_state == S_DRAIN_RD) || (r_state == S_DRAIN_WAIT)
                      || (r_state == S_DRAIN_TX);
    assign w_latch     = Samp_en && (((r_state == S_ARM) && w_start_hit)
                      || ((r_state == S_CAPTURE) && !r_burst && w_edge));
    assign w_wsel      = r_data[r_ch];

    // one_turn is asynchronous: two flops to resolve, third for edge detect
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_s0 <= 1'b0;
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s0 <= one_turn;
            r_s1 <= r_s0;
            r_s2 <= r_s1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            r_turn_cnt <= '0;
        else if (!Samp_en)
            r_turn_cnt <= '0;
        else if (w_edge)
            r_turn_cnt <= (r_turn_cnt == TURN_LAST) ? 16'd0 : r_turn_cnt + 16'd1;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:
                if (Samp_en) w_next = S_ARM;
            S_ARM:
                if (!Samp_en) w_next = S_IDLE;
                else if (w_start_hit) w_next = S_CAPTURE;
            S_CAPTURE:
                if (!Samp_en) w_next = S_IDLE;
                else if (w_burst_end && r_pt == LAST_PT) w_next = S_DRAIN_RD;
            S_DRAIN_RD:
                w_next = S_DRAIN_WAIT;
            S_DRAIN_WAIT:
                if (r_wait == WAIT_LAST) w_next = S_DRAIN_TX;
            S_DRAIN_TX:
                if (w_accept) begin
                    if (!w_last_word) w_next = S_DRAIN_RD;
                    else w_next = Samp_en ? S_ARM : S_IDLE;
                end
            default:
                w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < 4; i++) r_data[i] <= '0;
        end else if (w_latch) begin
            r_data[0] <= data_in0;
            r_data[1] <= data_in1;
            r_data[2] <= data_in2;
            r_data[3] <= data_in3;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_burst    <= 1'b0;
            r_ch       <= '0;
            r_pt       <= '0;
            r_rd_addr  <= '0;
            r_wait     <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (w_draining && Samp_en && w_start_hit) overrun <= 1'b1;
            case (r_state)
                S_IDLE, S_ARM: begin
                    r_ch      <= '0;
                    r_pt      <= '0;
                    r_rd_addr <= '0;
                    r_burst   <= w_latch;
                end
                S_CAPTURE: begin
                    if (!Samp_en) begin
                        r_burst <= 1'b0;
                        r_ch    <= '0;
                        r_pt    <= '0;
                    end else if (r_burst) begin
                        r_ch <= r_ch + 2'd1;
                        if (w_edge) overrun <= 1'b1;
                        if (r_ch == 2'd3) begin
                            r_burst <= 1'b0;
                            r_pt    <= r_pt + 8'd1;
                        end
                    end else if (w_edge) begin
                        r_burst <= 1'b1;
                    end
                end
                S_DRAIN_RD:
                    r_wait <= '0;
                S_DRAIN_WAIT:
                    r_wait <= r_wait + 4'd1;
                S_DRAIN_TX: begin
                    if (!tx_valid) begin
                        tx_data  <= ram_q;
                        tx_valid <= 1'b1;
                    end else if (tx_ready) begin
                        tx_valid <= 1'b0;
                        if (w_last_word) frame_done <= 1'b1;
                        else r_rd_addr <= r_rd_addr + 10'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ram_wren  = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        busy      = 1'b0;
        case (r_state)
            S_CAPTURE: begin
                busy = 1'b1;
                if (r_burst) begin
                    ram_wren = 1'b1;
                    ram_addr = {r_pt, r_ch};
`ifdef CAPTURE_TAG_EN
                    ram_wdata = {r_ch, w_wsel};
`else
                    ram_wdata = {2'b00, w_wsel};
`endif
                end
            end
            S_DRAIN_RD, S_DRAIN_WAIT, S_DRAIN_TX: begin
                busy     = 1'b1;
                ram_addr = r_rd_addr;
            end
            default: ;
        endcase
    end
endmodule
